wb_regfile: RTL and testbench

- Writeback stage of the five-stage RV32I pipeline, directly downstream of the ME stage.
- Consumes the mem_wb_t pipeline register. Formats load data, selects the writeback value and commits it to the 32-entry integer register file.
- Serves the two combinational read ports used by ID, with write-first bypass.
- Maintains retirement and cycle counters.

---
 rtl/wb_regfile_pkg.sv | 29 ++
 rtl/wb_regfile_regfile.sv | 49 ++++
 rtl/wb_regfile.sv | 102 ++++++++++
 tb/tb_wb_regfile.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared types for the writeback stage: ME->WB pipeline register layout,
// writeback source select and RV32I load funct3 encodings.
package wb_regfile_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_PC4  = 2'd2
    } wb_sel_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        wb_en;
        wb_sel_t     wb_sel;
        logic [31:0] alu_res;
        logic [31:0] ld_data;
        logic [2:0]  ld_f3;
        logic [1:0]  addr_lo;
        logic [31:0] pc;
    } mem_wb_t;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/wb_regfile_regfile.sv
// Integer register array: two combinational read ports with write-first
// bypass, x0 hardwired to zero, synchronous clear.
module wb_regfile_regfile #(
    parameter int AddrWidth = 5,
    parameter int Width     = 32
) (
    input  logic                 iClk,
    input  logic                 iRst,
    input  logic                 iWrEn,
    input  logic [AddrWidth-1:0] iWrAddr,
    input  logic [Width-1:0]     iWrData,
    input  logic [AddrWidth-1:0] iAddrRs1,
    input  logic [AddrWidth-1:0] iAddrRs2,
    output logic [Width-1:0]     oRs1,
    output logic [Width-1:0]     oRs2
);

    localparam int unsigned NumRegs = 2 ** AddrWidth;

    logic [Width-1:0] mem [NumRegs];
    logic             wrLive;

    assign wrLive = iWrEn && (iWrAddr != '0);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                mem[i] <= '0;
            end
        end else if (wrLive) begin
            mem[iWrAddr] <= iWrData;
        end
    end

    always_comb begin
        oRs1 = '0;
        if (iAddrRs1 != '0) begin
            oRs1 = (wrLive && iWrAddr == iAddrRs1) ? iWrData : mem[iAddrRs1];
        end
    end

    always_comb begin
        oRs2 = '0;
        if (iAddrRs2 != '0) begin
            oRs2 = (wrLive && iWrAddr == iAddrRs2) ? iWrData : mem[iAddrRs2];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// RV32I writeback stage: load formatting, writeback select, commit control,
// retirement/cycle counters, and the integer register file.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int RegAddrWidth = 5,
    parameter int RegWidth     = 32,
    parameter int CntWidth     = 64
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic                    iEn,
    input  logic                    iStall,
    input  mem_wb_t                 iME,
    input  logic [RegAddrWidth-1:0] iAddrRs1,
    input  logic [RegAddrWidth-1:0] iAddrRs2,
    output logic [RegWidth-1:0]     oRs1,
    output logic [RegWidth-1:0]     oRs2,
    output logic                    oRetire,
    output logic                    oMisalign,
    output logic [CntWidth-1:0]     oCycle,
    output logic [CntWidth-1:0]     oInstret
);

    logic [31:0] shifted;
    logic [31:0] loadVal;
    logic [31:0] wbVal;
    logic        misalign;
    logic        commit;
    logic        wrEn;

    assign shifted = iME.ld_data >> {iME.addr_lo, 3'b000};

    always_comb begin
        loadVal = iME.ld_data;
        case (iME.ld_f3)
            F3_LB:   loadVal = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  loadVal = {24'd0, shifted[7:0]};
            F3_LH:   loadVal = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  loadVal = {16'd0, shifted[15:0]};
            default: loadVal = iME.ld_data;
        endcase
    end

    // Reserved funct3 values behave as LW, so they share the word alignment rule.
    always_comb begin
        misalign = 1'b0;
        if (iME.valid && iME.wb_sel == WB_LOAD) begin
            case (iME.ld_f3)
                F3_LB, F3_LBU: misalign = 1'b0;
                F3_LH, F3_LHU: misalign = iME.addr_lo[0];
                default:       misalign = |iME.addr_lo;
            endcase
        end
    end

    always_comb begin
        wbVal = iME.alu_res;
        case (iME.wb_sel)
            WB_LOAD: wbVal = loadVal;
            WB_PC4:  wbVal = iME.pc + 32'd4;
            default: wbVal = iME.alu_res;
        endcase
    end

    assign commit = iEn && !iStall && !iRst && iME.valid && !misalign;
    assign wrEn   = commit && iME.wb_en;

    wb_regfile_regfile #(
        .AddrWidth(RegAddrWidth),
        .Width    (RegWidth)
    ) uRegfile (
        .iClk    (iClk),
        .iRst    (iRst),
        .iWrEn   (wrEn),
        .iWrAddr (iME.rd),
        .iWrData (wbVal),
        .iAddrRs1(iAddrRs1),
        .iAddrRs2(iAddrRs2),
        .oRs1    (oRs1),
        .oRs2    (oRs2)
    );

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oCycle    <= '0;
            oInstret  <= '0;
            oRetire   <= 1'b0;
            oMisalign <= 1'b0;
        end else begin
            if (iEn) begin
                oCycle <= oCycle + CntWidth'(1);
            end
            if (commit) begin
                oInstret <= oInstret + CntWidth'(1);
            end
            oRetire   <= commit;
            oMisalign <= misalign && iEn && !iStall;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed cases plus randomized traffic
// compared against a behavioural model of the writeback stage.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iEn;
    logic        iStall;
    mem_wb_t     iME;
    logic [4:0]  iAddrRs1;
    logic [4:0]  iAddrRs2;
    logic [31:0] oRs1;
    logic [31:0] oRs2;
    logic        oRetire;
    logic        oMisalign;
    logic [63:0] oCycle;
    logic [63:0] oInstret;

    always #5 iClk = ~iClk;

    wb_regfile #(
        .RegAddrWidth(5),
        .RegWidth    (32),
        .CntWidth    (64)
    ) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iEn      (iEn),
        .iStall   (iStall),
        .iME      (iME),
        .iAddrRs1 (iAddrRs1),
        .iAddrRs2 (iAddrRs2),
        .oRs1     (oRs1),
        .oRs2     (oRs2),
        .oRetire  (oRetire),
        .oMisalign(oMisalign),
        .oCycle   (oCycle),
        .oInstret (oInstret)
    );

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] mReg [32];
    logic [63:0] mCycle;
    logic [63:0] mInstret;
    logic        mRetire;
    logic        mMisalign;
    mem_wb_t     me;
    logic [31:0] obsRs1;
    logic [31:0] obsRs2;
    logic [63:0] c0;
    logic [63:0] i0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit isMisaligned(input logic [2:0] f3, input logic [1:0] lo);
        int size;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            default:    size = 4;
        endcase
        return (int'(lo) % size) != 0;
    endfunction

    function automatic logic [31:0] fmtLoad(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] lo);
        logic [31:0] s;
        logic [31:0] b;
        s = d >> (8 * int'(lo));
        case (f3)
            3'd0: begin b = s % 256;   return (b >= 128)   ? b - 32'd256   : b; end
            3'd4: return s % 256;
            3'd1: begin b = s % 65536; return (b >= 32768) ? b - 32'd65536 : b; end
            3'd5: return s % 65536;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] wbValue(input mem_wb_t m);
        case (m.wb_sel)
            WB_LOAD: return fmtLoad(m.ld_data, m.ld_f3, m.addr_lo);
            WB_PC4:  return m.pc + 32'd4;
            default: return m.alu_res;
        endcase
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] a, input bit we, input logic [4:0] rd,
                                              input logic [31:0] wv);
        if (a == 0) return 32'd0;
        if (we && rd == a) return wv;
        return mReg[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mReg[i] = 32'd0;
        mCycle    = 64'd0;
        mInstret  = 64'd0;
        mRetire   = 1'b0;
        mMisalign = 1'b0;
    endtask

    // One clock: drive at the falling edge, check reads before the rising edge,
    // check registered state at the next falling edge.
    task automatic step(input bit en, input bit stall, input bit rst, input logic [4:0] a1, input logic [4:0] a2);
        bit          mis;
        bit          com;
        bit          we;
        logic [31:0] wv;
        iEn = en; iStall = stall; iRst = rst; iME = me; iAddrRs1 = a1; iAddrRs2 = a2;
        mis = me.valid && me.wb_sel == WB_LOAD && isMisaligned(me.ld_f3, me.addr_lo);
        com = en && !stall && !rst && me.valid && !mis;
        we  = com && me.wb_en && me.rd != 0;
        wv  = wbValue(me);
        #1;
        obsRs1 = oRs1;
        obsRs2 = oRs2;
        checkEq("rs1", {32'd0, oRs1}, {32'd0, modelRead(a1, we, me.rd, wv)});
        checkEq("rs2", {32'd0, oRs2}, {32'd0, modelRead(a2, we, me.rd, wv)});
        @(posedge iClk);
        if (rst) begin
            modelReset();
        end else begin
            if (we) mReg[me.rd] = wv;
            if (en) mCycle = mCycle + 1;
            if (com) mInstret = mInstret + 1;
            mRetire   = com;
            mMisalign = mis && en && !stall;
        end
        @(negedge iClk);
        checkEq("retire",   {63'd0, oRetire},   {63'd0, mRetire});
        checkEq("misalign", {63'd0, oMisalign}, {63'd0, mMisalign});
        checkEq("cycle",    oCycle,   mCycle);
        checkEq("instret",  oInstret, mInstret);
    endtask

    task automatic readChk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        me.valid = 1'b0;
        step(1'b0, 1'b0, 1'b0, a, a);
        checkEq(tag, {32'd0, obsRs1}, {32'd0, exp});
    endtask

    task automatic setMe(input wb_sel_t sel, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] ld, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] pc);
        me.valid = 1'b1; me.wb_en = 1'b1; me.wb_sel = sel; me.rd = rd; me.alu_res = alu;
        me.ld_data = ld; me.ld_f3 = f3; me.addr_lo = lo; me.pc = pc;
    endtask

    initial begin
        me = '0;
        iME = '0; iRst = 1'b1; iEn = 1'b0; iStall = 1'b0; iAddrRs1 = '0; iAddrRs2 = '0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        modelReset();

        checkEq("rstCycle",   oCycle,   64'd0);
        checkEq("rstInstret", oInstret, 64'd0);
        for (int a = 0; a < 32; a++) readChk("rstReg", 5'(a), 32'd0);

        setMe(WB_ALU, 5'd5, 32'hDEADBEEF, 32'd0, F3_LW, 2'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd5, 5'd0);
        checkEq("bypassX5", {32'd0, obsRs1}, {32'd0, 32'hDEADBEEF});
        checkEq("retireX5", {63'd0, oRetire}, 64'd1);
        readChk("arrayX5", 5'd5, 32'hDEADBEEF);

        setMe(WB_LOAD, 5'd10, 32'd0, 32'h80FF7F01, F3_LB,  2'd2, 32'd0); step(1'b1, 1'b0, 1'b0, 5'd10, 5'd0);
        setMe(WB_LOAD, 5'd11, 32'd0, 32'h80FF7F01, F3_LBU, 2'd3, 32'd0); step(1'b1, 1'b0, 1'b0, 5'd11, 5'd0);
        setMe(WB_LOAD, 5'd12, 32'd0, 32'h80FF7F01, F3_LH,  2'd0, 32'd0); step(1'b1, 1'b0, 1'b0, 5'd12, 5'd0);
        setMe(WB_LOAD, 5'd13, 32'd0, 32'h80FF7F01, F3_LHU, 2'd2, 32'd0); step(1'b1, 1'b0, 1'b0, 5'd13, 5'd0);
        readChk("lb",  5'd10, 32'hFFFFFFFF);
        readChk("lbu", 5'd11, 32'h00000080);
        readChk("lh",  5'd12, 32'h00007F01);
        readChk("lhu", 5'd13, 32'h000080FF);

        setMe(WB_ALU, 5'd7, 32'h11111111, 32'd0, F3_LW, 2'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        i0 = mInstret;
        setMe(WB_LOAD, 5'd7, 32'd0, 32'hCAFEF00D, F3_LW, 2'd1, 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
        checkEq("misPulse",   {63'd0, oMisalign}, 64'd1);
        checkEq("misInstret", oInstret, i0);
        readChk("misX7", 5'd7, 32'h11111111);

        setMe(WB_ALU, 5'd1, 32'h55555555, 32'd0, F3_LW, 2'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        i0 = mInstret;
        setMe(WB_ALU, 5'd0, 32'h12345678, 32'd0, F3_LW, 2'd0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        setMe(WB_PC4, 5'd1, 32'd0, 32'd0, F3_LW, 2'd0, 32'hFFFFFFFC);
        step(1'b1, 1'b0, 1'b0, 5'd1, 5'd0);
        checkEq("x0x1Instret", oInstret, i0 + 64'd2);
        readChk("x0Zero", 5'd0, 32'd0);
        readChk("pc4Wrap", 5'd1, 32'd0);

        c0 = mCycle; i0 = mInstret;
        setMe(WB_ALU, 5'd9, 32'h0BADF00D, 32'd0, F3_LW, 2'd0, 32'd0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 5'd9, 5'd0);
        step(1'b1, 1'b0, 1'b0, 5'd9, 5'd0);
        checkEq("stallCycle",   oCycle,   c0 + 64'd4);
        checkEq("stallInstret", oInstret, i0 + 64'd1);
        readChk("stallX9", 5'd9, 32'h0BADF00D);

        setMe(WB_ALU, 5'd12, 32'hAAAAAAAA, 32'd0, F3_LW, 2'd0, 32'd0);
        step(1'b1, 1'b0, 1'b1, 5'd12, 5'd5);
        checkEq("rstWrCycle", oCycle, 64'd0);
        readChk("rstWrX12", 5'd12, 32'd0);
        readChk("rstWrX5",  5'd5,  32'd0);

        for (int n = 0; n < 400; n++) begin
            me.valid   = $urandom_range(0, 3) != 0;
            me.rd      = 5'($urandom);
            me.wb_en   = $urandom_range(0, 4) != 0;
            me.wb_sel  = wb_sel_t'($urandom_range(0, 2));
            me.alu_res = $urandom;
            me.ld_data = $urandom;
            me.ld_f3   = 3'($urandom);
            me.addr_lo = 2'($urandom);
            me.pc      = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 49) == 0,
                 5'($urandom), 5'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
